// File: rtl/calc_sequencer_pkg.sv
// Shared encodings for the calculator operation sequencer: mode, unit-select
// and size codes, FSM state encoding and small decode helpers.
package calc_sequencer_pkg;

    localparam logic [2:0] MODE_FP    = 3'b000;
    localparam logic [2:0] MODE_ARITH = 3'b001;
    localparam logic [2:0] MODE_BIT   = 3'b010;
    localparam logic [2:0] MODE_LOGIC = 3'b011;
    localparam logic [2:0] MODE_FETCH = 3'b100;
    localparam logic [2:0] MODE_STORE = 3'b101;

    localparam logic [1:0] SEL_FP    = 2'd0;
    localparam logic [1:0] SEL_ARITH = 2'd1;
    localparam logic [1:0] SEL_BIT   = 2'd2;
    localparam logic [1:0] SEL_LOGIC = 2'd3;

    localparam logic [1:0] SIZE_1 = 2'd0;
    localparam logic [1:0] SIZE_2 = 2'd1;
    localparam logic [1:0] SIZE_4 = 2'd2;
    localparam logic [1:0] SIZE_8 = 2'd3;

    // Logic-unit op that takes a single operand
    localparam logic [2:0] OP_NOT = 3'b110;

    typedef enum logic [2:0] {
        StIdle,
        StSelOp,
        StSelSize,
        StLoadA,
        StLoadB,
        StIssue,
        StWait,
        StDone
    } state_e;

    function automatic logic is_illegal_mode(logic [2:0] mode);
        return mode[2] & mode[1];
    endfunction

    function automatic logic [1:0] unit_for_mode(logic [2:0] mode);
        case (mode)
            MODE_ARITH: return SEL_ARITH;
            MODE_BIT:   return SEL_BIT;
            MODE_LOGIC: return SEL_LOGIC;
            default:    return SEL_FP;
        endcase
    endfunction

    // Chunk count for a size code, clipped to the chunks that fit in one operand
    function automatic int unsigned chunks_for_size(logic [1:0] size, int unsigned max_chunks);
        int unsigned n;
        case (size)
            SIZE_1:  n = 1;
            SIZE_2:  n = 2;
            SIZE_4:  n = 4;
            SIZE_8:  n = 8;
            default: n = 1;
        endcase
        return (n > max_chunks) ? max_chunks : n;
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Handshake bundle between the calculator sequencer and its environment
// (switch/confirm front end and the FP/arith/bit/logic units).
interface calc_sequencer_if #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CHUNK_W = 16
);
    logic               confirm;
    logic [CHUNK_W-1:0] switches;
    logic               unit_req;
    logic [1:0]         unit_sel;
    logic [2:0]         unit_op;
    logic [DATA_W-1:0]  opa;
    logic [DATA_W-1:0]  opb;
    logic               unit_done;
    logic [DATA_W-1:0]  unit_result;
    logic [DATA_W-1:0]  result;
    logic               result_valid;
    logic               sign;
    logic               busy;
    logic               err;

    // Sequencer side
    modport slave (
        input  confirm, switches, unit_done, unit_result,
        output unit_req, unit_sel, unit_op, opa, opb, result, result_valid, sign, busy, err
    );

    // Environment side
    modport master (
        output confirm, switches, unit_done, unit_result,
        input  unit_req, unit_sel, unit_op, opa, opb, result, result_valid, sign, busy, err
    );
endinterface

// File: rtl/calc_sequencer_operand_assembler.sv
// Builds one DATA_W operand from CHUNK_W switch chunks, LSB chunk first.
// Shared by LOAD_A and LOAD_B; clears itself after the last chunk so the
// next operand starts from zero.
module calc_sequencer_operand_assembler
    import calc_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CHUNK_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_set_size,
    input  logic [1:0]         i_size,
    input  logic               i_wr,
    input  logic [CHUNK_W-1:0] i_chunk,
    output logic [DATA_W-1:0]  o_data_next,
    output logic               o_last
);
    localparam int unsigned NCHUNK = DATA_W / CHUNK_W;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned TGT_W  = $clog2(NCHUNK + 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [TGT_W-1:0]  r_target;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_chunk_shifted;

    // Place the incoming chunk at its slot; value includes the chunk being written
    always_comb begin
        w_chunk_shifted = DATA_W'(i_chunk) << (CHUNK_W * r_cnt);
        o_data_next     = r_data | w_chunk_shifted;
        o_last          = (TGT_W'(r_cnt) + TGT_W'(1)) == r_target;
    end

    // Chunk counter, target count and partial operand
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_target <= TGT_W'(1);
            r_data   <= '0;
        end else if (i_set_size) begin
            r_cnt    <= '0;
            r_target <= TGT_W'(chunks_for_size(i_size, NCHUNK));
            r_data   <= '0;
        end else if (i_wr) begin
            if (o_last) begin
                r_cnt  <= '0;
                r_data <= '0;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_data <= o_data_next;
            end
        end
    end
endmodule

// File: rtl/calc_sequencer.sv
// Calculator operation sequencer: collects mode/op/size/operands from the
// switches on confirm pulses, dispatches to a unit over req/done, and keeps
// results in a small register file for store/fetch.
// Optional WAIT watchdog: define SEQ_TIMEOUT_EN.
module calc_sequencer
    import calc_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned CHUNK_W     = 16,
    parameter int unsigned NUM_REGS    = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic            clk,
    input logic            rst,
    calc_sequencer_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    if ((DATA_W % CHUNK_W) != 0 || CHUNK_W < 3 || NUM_REGS < 2 || NUM_REGS > 8 ||
        (NUM_REGS & (NUM_REGS - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("calc_sequencer: illegal parameter combination");
    end

    state_e            r_state;
    logic [2:0]        r_mode;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_result;
    logic              r_result_valid;
    logic              r_err;
    logic              r_unit_req;
    logic [1:0]        r_unit_sel;
    logic [2:0]        r_unit_op;

    logic [IDX_W-1:0]  w_idx;
    logic              w_skip_b;
    logic              w_asm_set;
    logic              w_asm_wr;
    logic              w_asm_last;
    logic [DATA_W-1:0] w_asm_data;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC);
    logic [WAIT_W-1:0] r_wait_cnt;
`endif

    // Decode helpers for the current operation
    always_comb begin
        w_idx     = r_op[IDX_W-1:0];
        w_skip_b  = (r_mode == MODE_LOGIC) && (r_op == OP_NOT);
        w_asm_set = bus.confirm && (r_state == StSelSize);
        w_asm_wr  = bus.confirm && ((r_state == StLoadA) || (r_state == StLoadB));
    end

    calc_sequencer_operand_assembler #(
        .DATA_W (DATA_W),
        .CHUNK_W(CHUNK_W)
    ) u_assembler (
        .clk        (clk),
        .rst        (rst),
        .i_set_size (w_asm_set),
        .i_size     (bus.switches[1:0]),
        .i_wr       (w_asm_wr),
        .i_chunk    (bus.switches),
        .o_data_next(w_asm_data),
        .o_last     (w_asm_last)
    );

    // Sequencer FSM with registered outputs and inline register file
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= StIdle;
            r_mode         <= '0;
            r_op           <= '0;
            r_opa          <= '0;
            r_opb          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_unit_req     <= 1'b0;
            r_unit_sel     <= '0;
            r_unit_op      <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
`ifdef SEQ_TIMEOUT_EN
            r_wait_cnt     <= '0;
`endif
        end else begin
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.confirm) begin
                        if (is_illegal_mode(bus.switches[2:0])) begin
                            r_err <= 1'b1;
                        end else begin
                            r_mode  <= bus.switches[2:0];
                            r_opa   <= '0;
                            r_opb   <= '0;
                            r_state <= StSelOp;
                        end
                    end
                end
                StSelOp: begin
                    if (bus.confirm) begin
                        r_op    <= bus.switches[2:0];
                        r_state <= StSelSize;
                    end
                end
                StSelSize: begin
                    if (bus.confirm) begin
                        if (r_mode == MODE_FETCH) begin
                            r_result       <= r_regs[w_idx];
                            r_result_valid <= 1'b1;
                            r_state        <= StDone;
                        end else begin
                            r_state <= StLoadA;
                        end
                    end
                end
                StLoadA: begin
                    if (bus.confirm && w_asm_last) begin
                        r_opa <= w_asm_data;
                        if (r_mode == MODE_STORE) begin
                            r_regs[w_idx]  <= w_asm_data;
                            r_result       <= w_asm_data;
                            r_result_valid <= 1'b1;
                            r_state        <= StDone;
                        end else if (w_skip_b) begin
                            r_state <= StIssue;
                        end else begin
                            r_state <= StLoadB;
                        end
                    end
                end
                StLoadB: begin
                    if (bus.confirm && w_asm_last) begin
                        r_opb   <= w_asm_data;
                        r_state <= StIssue;
                    end
                end
                StIssue: begin
                    r_unit_req <= 1'b1;
                    r_unit_sel <= unit_for_mode(r_mode);
                    r_unit_op  <= r_op;
                    r_state    <= StWait;
`ifdef SEQ_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                StWait: begin
                    // A done pulse takes priority over any confirm in the same cycle
                    if (bus.unit_done) begin
                        r_result       <= bus.unit_result;
                        r_result_valid <= 1'b1;
                        r_unit_req     <= 1'b0;
                        r_state        <= StDone;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
                        r_err      <= 1'b1;
                        r_unit_req <= 1'b0;
                        r_state    <= StIdle;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
`endif
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.unit_req     = r_unit_req;
    assign bus.unit_sel     = r_unit_sel;
    assign bus.unit_op      = r_unit_op;
    assign bus.opa          = r_opa;
    assign bus.opb          = r_opb;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.sign         = r_result[DATA_W-1];
    assign bus.busy         = (r_state != StIdle);
    assign bus.err          = r_err;
endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed cases plus randomized
// operations compared against an operation-level reference model.
module tb_calc_sequencer;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned CHUNK_W  = 16;
    localparam int unsigned NUM_REGS = 4;
`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYC = 16;
`else
    localparam int unsigned TIMEOUT_CYC = 1024;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    calc_sequencer_if #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) bus ();

    calc_sequencer #(
        .DATA_W     (DATA_W),
        .CHUNK_W    (CHUNK_W),
        .NUM_REGS   (NUM_REGS),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [63:0] m_regs [NUM_REGS];
    logic [63:0] m_result;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic confirm_with(input logic [15:0] v);
        bus.switches = v;
        bus.confirm  = 1'b1;
        tick();
        bus.confirm  = 1'b0;
        bus.switches = 16'($urandom);
    endtask

    function automatic int n_chunks(input logic [1:0] size);
        int n;
        n = 1 << size;
        return (n > 4) ? 4 : n;
    endfunction

    function automatic logic [63:0] load_mask(input int n);
        if (n >= 4) return '1;
        return (64'd1 << (16 * n)) - 64'd1;
    endfunction

    // Expect the DONE cycle now, then IDLE one cycle later
    task automatic check_done(input string tag);
        check_eq({tag, "_rv"}, bus.result_valid, 1'b1);
        check_eq({tag, "_result"}, bus.result, m_result);
        check_eq({tag, "_sign"}, bus.sign, m_result[63]);
        check_eq({tag, "_req_low"}, bus.unit_req, 1'b0);
        tick();
        check_eq({tag, "_rv_drop"}, bus.result_valid, 1'b0);
        check_eq({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    // Mode/op/size plus operand confirms; leaves the DUT in WAIT with req high
    task automatic go_to_wait(input logic [2:0] mode, input logic [2:0] op, input logic [1:0] size,
                              input logic [63:0] a_raw, input logic [63:0] b_raw);
        int n;
        bit skip_b;
        logic [63:0] a;
        logic [63:0] b;
        n      = n_chunks(size);
        a      = a_raw & load_mask(n);
        skip_b = (mode == 3'b011) && (op == 3'b110);
        b      = skip_b ? 64'd0 : (b_raw & load_mask(n));
        confirm_with({13'($urandom), mode});
        check_eq("busy_sel_op", bus.busy, 1'b1);
        confirm_with({13'($urandom), op});
        confirm_with({14'($urandom), size});
        for (int k = 0; k < n; k++) confirm_with(a[16*k +: 16]);
        if (!skip_b) for (int k = 0; k < n; k++) confirm_with(b[16*k +: 16]);
        check_eq("issue_req_low", bus.unit_req, 1'b0);
        tick();
        check_eq("wait_req", bus.unit_req, 1'b1);
        check_eq("wait_sel", bus.unit_sel, mode[1:0]);
        check_eq("wait_op", bus.unit_op, op);
        check_eq("wait_opa", bus.opa, a);
        check_eq("wait_opb", bus.opb, b);
    endtask

    task automatic do_op(input logic [2:0] mode, input logic [2:0] op, input logic [1:0] size,
                         input logic [63:0] a_raw, input logic [63:0] b_raw,
                         input logic [63:0] res, input int lat);
        int n;
        int idx;
        logic [63:0] a;
        n   = n_chunks(size);
        a   = a_raw & load_mask(n);
        idx = int'(op) % NUM_REGS;
        if (mode == 3'b100 || mode == 3'b101) begin
            confirm_with({13'($urandom), mode});
            confirm_with({13'($urandom), op});
            confirm_with({14'($urandom), size});
            if (mode == 3'b100) begin
                m_result = m_regs[idx];
                check_done("fetch");
            end else begin
                for (int k = 0; k < n; k++) confirm_with(a[16*k +: 16]);
                m_regs[idx] = a;
                m_result    = a;
                check_done("store");
            end
            return;
        end
        go_to_wait(mode, op, size, a_raw, b_raw);
        for (int i = 0; i < lat; i++) begin
            bus.confirm = 1'($urandom);
            tick();
            bus.confirm = 1'b0;
            check_eq("wait_hold_req", bus.unit_req, 1'b1);
        end
        // Done may coincide with a stray confirm; done must win
        bus.unit_done   = 1'b1;
        bus.unit_result = res;
        bus.confirm     = 1'($urandom);
        tick();
        bus.unit_done   = 1'b0;
        bus.confirm     = 1'b0;
        m_result        = res;
        check_done("unit");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [2:0]  md;
        bus.confirm     = 1'b0;
        bus.switches    = '0;
        bus.unit_done   = 1'b0;
        bus.unit_result = '0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_result = '0;

        #2;
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_result", bus.result, 64'd0);
        check_eq("rst_req", bus.unit_req, 1'b0);
        check_eq("rst_rv", bus.result_valid, 1'b0);
        check_eq("rst_err", bus.err, 1'b0);
        check_eq("rst_opa", bus.opa, 64'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Arith add, four chunks per operand
        do_op(3'b001, 3'b000, 2'd2, 64'd5, 64'd3, 64'd8, 2);
        // Single-chunk load: upper bits must stay zero
        do_op(3'b000, 3'b010, 2'd0, 64'h1234_5678_9abc_beef, 64'hffff_0000_1111_2222,
              64'h0123_4567_89ab_cdef, 0);
        // Store then fetch with the sign bit set
        do_op(3'b101, 3'b010, 2'd3, 64'h8000_0000_0000_0001, 64'd0, 64'd0, 0);
        do_op(3'b100, 3'b010, 2'd0, 64'd0, 64'd0, 64'd0, 0);
        check_eq("fetch_sign", bus.result[63], 1'b1);
        // Illegal modes
        for (int i = 6; i < 8; i++) begin
            md = 3'(i);
            confirm_with({13'($urandom), md});
            check_eq("illegal_err", bus.err, 1'b1);
            check_eq("illegal_idle", bus.busy, 1'b0);
            tick();
            check_eq("illegal_err_drop", bus.err, 1'b0);
        end
        // Logic NOT: single operand
        do_op(3'b011, 3'b110, 2'd1, 64'($urandom), 64'($urandom), 64'hdead_beef_0000_0001, 1);
        // Done outside WAIT is ignored
        bus.unit_done   = 1'b1;
        bus.unit_result = {32'($urandom), 32'($urandom)};
        tick();
        bus.unit_done   = 1'b0;
        check_eq("stray_done_result", bus.result, m_result);
        check_eq("stray_done_rv", bus.result_valid, 1'b0);

        // Randomized operations, including illegal modes
        for (int t = 0; t < 60; t++) begin
            md = 3'($urandom_range(0, 7));
            r  = {32'($urandom), 32'($urandom)};
            if (md >= 3'd6) begin
                confirm_with({13'($urandom), md});
                check_eq("rand_illegal_err", bus.err, 1'b1);
                check_eq("rand_illegal_idle", bus.busy, 1'b0);
            end else begin
                do_op(md, 3'($urandom), 2'($urandom), {32'($urandom), 32'($urandom)},
                      {32'($urandom), 32'($urandom)}, r, $urandom_range(0, 4));
            end
        end

        // WAIT with no done: watchdog when enabled, otherwise blocks
        go_to_wait(3'b001, 3'b011, 2'd0, 64'($urandom), 64'($urandom));
`ifdef SEQ_TIMEOUT_EN
        for (int i = 0; i < int'(TIMEOUT_CYC) - 1; i++) begin
            tick();
            check_eq("timeout_early_err", bus.err, 1'b0);
        end
        tick();
        check_eq("timeout_err", bus.err, 1'b1);
        check_eq("timeout_idle", bus.busy, 1'b0);
        check_eq("timeout_req", bus.unit_req, 1'b0);
        check_eq("timeout_rv", bus.result_valid, 1'b0);
        check_eq("timeout_result", bus.result, m_result);
`else
        repeat (1000) tick();
        check_eq("block_busy", bus.busy, 1'b1);
        check_eq("block_req", bus.unit_req, 1'b1);
        check_eq("block_err", bus.err, 1'b0);
        r               = {32'($urandom), 32'($urandom)};
        bus.unit_done   = 1'b1;
        bus.unit_result = r;
        tick();
        bus.unit_done   = 1'b0;
        m_result        = r;
        check_done("block_release");
`endif

        // Asynchronous reset while waiting on a unit
        go_to_wait(3'b010, 3'b001, 2'd1, 64'($urandom), 64'($urandom));
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_req", bus.unit_req, 1'b0);
        check_eq("async_rst_result", bus.result, 64'd0);
        check_eq("async_rst_busy", bus.busy, 1'b0);
        m_result = '0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        tick();
        rst             = 1'b1;
        bus.unit_done   = 1'b1;
        bus.unit_result = '1;
        tick();
        bus.unit_done   = 1'b0;
        check_eq("post_rst_done_result", bus.result, 64'd0);
        check_eq("post_rst_done_rv", bus.result_valid, 1'b0);
        check_eq("post_rst_done_busy", bus.busy, 1'b0);
        // Register file must have been cleared
        for (int i = 0; i < NUM_REGS; i++) begin
            do_op(3'b100, 3'(i), 2'($urandom), 64'd0, 64'd0, 64'd0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
